mpsoc_ahb3_master_port: RTL and testbench
=========================================

Name: mpsoc_ahb3_master_port

Overview:
AHB3-Lite initiator that converts a simple valid/ready command stream into single AHB3-Lite transfers, and returns read data and error status on a response strobe. It is the master-side counterpart to the mpsoc_ahb3_spram slave, and drives that slave in regression and in CPU-less DMA/test paths. Address and data phases are pipelined, so throughput is one transfer per cycle on zero-wait slaves.

Parameters:
PLEN, 64, address width (HADDR, cmd_addr)
XLEN, 64, data width (HWDATA/HRDATA, cmd_wdata, rsp_rdata)
HPROT_DEFAULT, 4'b0011, HPROT value driven while no transfer is active

Ports:
HCLK  input  1  bus clock; all logic is rising-edge
HRESETn  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  command accepted on the edge where cmd_valid && cmd_ready
cmd_write  input  1  1=write, 0=read
cmd_addr  input  PLEN  byte address
cmd_size  input  3  HSIZE encoding
cmd_wdata  input  XLEN  write data, already lane-aligned by the caller
cmd_prot  input  4  HPROT for this transfer
cmd_lock  input  1  HMASTLOCK for this transfer
rsp_valid  output  1  one-cycle strobe, one per completed transfer
rsp_write  output  1  transfer type of the completed transfer
rsp_rdata  output  XLEN  HRDATA captured at completion (reads only)
rsp_err  output  1  HRESP was ERROR for this transfer
HSEL  output  1  high whenever HTRANS=NONSEQ
HADDR  output  PLEN
HWDATA  output  XLEN
HRDATA  input  XLEN
HWRITE  output  1
HSIZE  output  3
HBURST  output  3  constant 3'b000 (SINGLE)
HPROT  output  4
HTRANS  output  2  IDLE=2'b00 or NONSEQ=2'b10 only
HMASTLOCK  output  1
HREADY  input  1  bus ready (slave HREADYOUT)
HRESP  input  1  0=OKAY, 1=ERROR

Behaviour:
- Reset values: HTRANS=IDLE, HSEL=0, HADDR=0, HWDATA=0, HWRITE=0, HSIZE=0, HBURST=0, HPROT=HPROT_DEFAULT, HMASTLOCK=0, rsp_valid=0, rsp_write=0, rsp_rdata=0, rsp_err=0; the internal address-phase and data-phase registers are empty.
- Reset asserted mid-operation: in-flight transfers are dropped and produce no response, and all outputs take their reset values immediately.
- Two pipeline stages:
  - Address-phase (AP) stage: all AHB control outputs are registered from AP.
  - Data-phase (DP) stage: HWDATA is registered from DP.
- cmd_ready = HREADY && !err_cycle1 && !replay. The path is combinational from HREADY.
- On an edge with HREADY=1:
  - DP <= AP (if AP valid).
  - AP <= accepted command, otherwise AP empty (HTRANS=IDLE, HPROT=HPROT_DEFAULT, HMASTLOCK=0).
- Latency: a command accepted at edge E0 shows HTRANS=NONSEQ from E0 onward. With zero wait states, the address phase completes at E1, the data phase completes at E2, and rsp_valid is high for the single cycle after E2.
- Completion: at an edge with HREADY=1 and DP valid, set rsp_valid=1, rsp_write=DP.write, rsp_err=HRESP and rsp_rdata=HRDATA (reads), or rsp_rdata unchanged (writes).
- Wait states (HREADY=0): AP, DP, HADDR/HTRANS/control and HWDATA all hold; no command is accepted and no response is generated.
- Error response, cycle 1 (HRESP=1, HREADY=0, DP valid):
  - Set err_cycle1.
  - In the next cycle, force HTRANS=IDLE and HSEL=0. The AP command is kept and marked replay.
- Error response, cycle 2 (HRESP=1, HREADY=1): the errored transfer completes with rsp_err=1, and DP is cleared.
- Replay: on the next cycle the held AP command is reissued as NONSEQ, and replay clears once its address phase is sampled. No command is lost or reordered.
- Responses are returned in command order. The block does not check address alignment against size.

Optional Feature:
- Macro: MPSOC_AHB3_MASTER_STATS_EN.
- Defined:
  - Adds input stat_clr (1), output stat_xfer_cnt (32) and output stat_err_cnt (32).
  - stat_xfer_cnt counts every rsp_valid; stat_err_cnt counts every rsp_valid with rsp_err=1.
  - Both counters saturate at 32'hFFFF_FFFF.
  - stat_clr zeroes both counters on the next edge and has priority over increment.
  - Reset value of both counters is 0.
- Not defined: the ports and counters are absent, and all other behaviour is identical.

Test Plan:
- Reset: hold HRESETn=0 with random inputs -> HTRANS=00, HSEL=0, HPROT=4'b0011, rsp_valid=0; cmd_ready equals HREADY.
- Single write then read: write addr 0x10, data 0xDEADBEEF_CAFEF00D, size 3; then read 0x10 against mpsoc_ahb3_spram -> rsp_valid exactly 2 cycles after each accept, read rsp_rdata=0xDEADBEEF_CAFEF00D, rsp_err=0.
- Back-to-back: 4 writes to 0x0,0x8,0x10,0x18, zero wait -> HTRANS=NONSEQ for 4 consecutive cycles, HWDATA follows one cycle behind HADDR, 4 consecutive rsp_valid pulses.
- Wait states: slave holds HREADY=0 for 3 cycles during the data phase of command A with command B in AP -> HADDR/HTRANS for B and HWDATA for A stable for all 3 cycles, cmd_ready=0, A's response arrives after the 4th cycle.
- Error with replay: A errors (HRESP=1/HREADY=0, then HRESP=1/HREADY=1) while B is in AP -> HTRANS=IDLE in error cycle 2, A response rsp_err=1, B reissued NONSEQ next cycle, B response rsp_err=0, order A then B.
- Stats (macro defined): 5 transfers with 1 error -> stat_xfer_cnt=5, stat_err_cnt=1; pulse stat_clr -> both 0 next cycle.

Source files
------------

// File: rtl/mpsoc_ahb3_master_port.sv
// mpsoc_ahb3_master_port: valid/ready command stream to pipelined single AHB3-Lite transfers.
// Define MPSOC_AHB3_MASTER_STATS_EN to add saturating transfer/error counters.
module mpsoc_ahb3_master_port #(
    parameter int         PLEN          = 64,
    parameter int         XLEN          = 64,
    parameter logic [3:0] HPROT_DEFAULT = 4'b0011
) (
    input  logic            HCLK,
    input  logic            HRESETn,
    input  logic            cmd_valid,
    output logic            cmd_ready,
    input  logic            cmd_write,
    input  logic [PLEN-1:0] cmd_addr,
    input  logic [2:0]      cmd_size,
    input  logic [XLEN-1:0] cmd_wdata,
    input  logic [3:0]      cmd_prot,
    input  logic            cmd_lock,
    output logic            rsp_valid,
    output logic            rsp_write,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    output logic            HSEL,
    output logic [PLEN-1:0] HADDR,
    output logic [XLEN-1:0] HWDATA,
    input  logic [XLEN-1:0] HRDATA,
    output logic            HWRITE,
    output logic [2:0]      HSIZE,
    output logic [2:0]      HBURST,
    output logic [3:0]      HPROT,
    output logic [1:0]      HTRANS,
    output logic            HMASTLOCK,
    input  logic            HREADY,
    input  logic            HRESP
`ifdef MPSOC_AHB3_MASTER_STATS_EN
    ,
    input  logic            stat_clr,
    output logic [31:0]     stat_xfer_cnt,
    output logic [31:0]     stat_err_cnt
`endif
);
    logic            nonseq, replay, err_cycle1, dp_valid, dp_write, accept;
    logic [XLEN-1:0] ap_wdata;

    assign cmd_ready = HREADY && !err_cycle1 && !replay;
    assign accept    = cmd_valid && cmd_ready;
    assign HTRANS    = {nonseq, 1'b0};
    assign HSEL      = nonseq;
    assign HBURST    = 3'b000;

    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            nonseq     <= 1'b0;
            replay     <= 1'b0;
            err_cycle1 <= 1'b0;
            dp_valid   <= 1'b0;
            dp_write   <= 1'b0;
            ap_wdata   <= '0;
            HADDR      <= '0;
            HWDATA     <= '0;
            HWRITE     <= 1'b0;
            HSIZE      <= 3'b000;
            HPROT      <= HPROT_DEFAULT;
            HMASTLOCK  <= 1'b0;
            rsp_valid  <= 1'b0;
            rsp_write  <= 1'b0;
            rsp_rdata  <= '0;
            rsp_err    <= 1'b0;
        end else begin
            rsp_valid <= HREADY && dp_valid;
            if (HREADY && dp_valid) begin
                rsp_write <= dp_write;
                rsp_err   <= HRESP;
                if (!dp_write) rsp_rdata <= HRDATA;
            end
            if (!HREADY) begin
                // first ERROR cycle: pull the pending address phase off the bus and keep it for replay
                if (HRESP && dp_valid && !err_cycle1) begin
                    err_cycle1 <= 1'b1;
                    nonseq     <= 1'b0;
                    replay     <= nonseq;
                end
            end else if (err_cycle1) begin
                err_cycle1 <= 1'b0;
                dp_valid   <= 1'b0;
                nonseq     <= replay;
            end else begin
                dp_valid <= nonseq;
                replay   <= 1'b0;
                nonseq   <= accept;
                if (nonseq) begin
                    dp_write <= HWRITE;
                    HWDATA   <= ap_wdata;
                end
                if (accept) begin
                    HADDR     <= cmd_addr;
                    HWRITE    <= cmd_write;
                    HSIZE     <= cmd_size;
                    HPROT     <= cmd_prot;
                    HMASTLOCK <= cmd_lock;
                    ap_wdata  <= cmd_wdata;
                end else begin
                    HPROT     <= HPROT_DEFAULT;
                    HMASTLOCK <= 1'b0;
                end
            end
        end
    end

`ifdef MPSOC_AHB3_MASTER_STATS_EN
    always_ff @(posedge HCLK or negedge HRESETn) begin
        if (!HRESETn) begin
            stat_xfer_cnt <= '0;
            stat_err_cnt  <= '0;
        end else if (stat_clr) begin
            stat_xfer_cnt <= '0;
            stat_err_cnt  <= '0;
        end else if (rsp_valid) begin
            if (stat_xfer_cnt != '1) stat_xfer_cnt <= stat_xfer_cnt + 1'b1;
            if (rsp_err && stat_err_cnt != '1) stat_err_cnt <= stat_err_cnt + 1'b1;
        end
    end
`endif
endmodule

// File: tb/tb_mpsoc_ahb3_master_port.sv
// tb_mpsoc_ahb3_master_port: drives mpsoc_ahb3_master_port against a behavioural AHB slave
// and an in-order transaction model.
module tb_mpsoc_ahb3_master_port;
    logic        HCLK = 1'b0, HRESETn = 1'b0;
    logic        cmd_valid = 1'b0, cmd_ready, cmd_write = 1'b0, cmd_lock = 1'b0;
    logic [63:0] cmd_addr = '0, cmd_wdata = '0;
    logic [2:0]  cmd_size = '0;
    logic [3:0]  cmd_prot = '0;
    logic        rsp_valid, rsp_write, rsp_err;
    logic [63:0] rsp_rdata;
    logic        HSEL, HWRITE, HMASTLOCK;
    logic        HREADY = 1'b1, HRESP = 1'b0;
    logic [63:0] HADDR, HWDATA, HRDATA = '0;
    logic [2:0]  HSIZE, HBURST;
    logic [3:0]  HPROT;
    logic [1:0]  HTRANS;
`ifdef MPSOC_AHB3_MASTER_STATS_EN
    logic        stat_clr = 1'b0;
    logic [31:0] stat_xfer_cnt, stat_err_cnt;
`endif

    always #5 HCLK = ~HCLK;

    mpsoc_ahb3_master_port dut (
        .HCLK(HCLK), .HRESETn(HRESETn),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write), .cmd_addr(cmd_addr),
        .cmd_size(cmd_size), .cmd_wdata(cmd_wdata), .cmd_prot(cmd_prot), .cmd_lock(cmd_lock),
        .rsp_valid(rsp_valid), .rsp_write(rsp_write), .rsp_rdata(rsp_rdata), .rsp_err(rsp_err),
        .HSEL(HSEL), .HADDR(HADDR), .HWDATA(HWDATA), .HRDATA(HRDATA), .HWRITE(HWRITE),
        .HSIZE(HSIZE), .HBURST(HBURST), .HPROT(HPROT), .HTRANS(HTRANS), .HMASTLOCK(HMASTLOCK),
        .HREADY(HREADY), .HRESP(HRESP)
`ifdef MPSOC_AHB3_MASTER_STATS_EN
        , .stat_clr(stat_clr), .stat_xfer_cnt(stat_xfer_cnt), .stat_err_cnt(stat_err_cnt)
`endif
    );

    typedef struct {
        logic        w;
        logic [63:0] a;
        logic [2:0]  sz;
        logic [63:0] d;
        logic [3:0]  p;
        logic        l;
        int          wt;
        int          lat;
        int          cyc;
        logic [63:0] rd;
        logic        e;
    } cmd_t;

    cmd_t        pend_q[$], iss_q[$], exp_q[$];
    cmd_t        cur;
    logic [63:0] ref_mem [32];
    logic [63:0] slv_mem [32];
    int          n_cmp = 0, n_bad = 0, cyc = 0, load = 0, n_rsp = 0, n_rsp_err = 0;
    bit          zw = 1, err_en = 0, have = 0, rp = 0;
    bit          s_dp = 0, s_w = 0, s_e = 0, s_e1 = 0;
    int          s_wait = 0;
    logic [63:0] s_a = '0, s_d = '0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cmd_t mk(input logic w, input logic [63:0] a, input logic [63:0] d,
                                input int wt, input int lat);
        cmd_t c;
        c.w = w; c.a = a; c.sz = 3'd3; c.d = d; c.p = 4'b1010; c.l = 1'b0;
        c.wt = wt; c.lat = lat; c.cyc = 0; c.rd = '0; c.e = 1'b0;
        return c;
    endfunction

    function automatic cmd_t rnd_cmd();
        cmd_t c;
        c = mk(1'($urandom_range(0, 1)), 64'($urandom_range(0, 31)) << 3,
               {$urandom, $urandom}, -1, -1);
        c.sz = 3'($urandom_range(0, 3));
        c.p  = 4'($urandom);
        c.l  = 1'($urandom_range(0, 1));
        return c;
    endfunction

    // reference: sequential semantics in acceptance order; addresses 0xC0-0xFF answer ERROR
    task automatic accept_cmd(input cmd_t c);
        c.cyc = cyc;
        c.e   = err_en && (c.a[7:6] == 2'b11);
        if (c.w && !c.e) ref_mem[c.a[7:3]] = c.d;
        if (!c.w) c.rd = ref_mem[c.a[7:3]];
        iss_q.push_back(c);
        exp_q.push_back(c);
    endtask

    task automatic tick();
        cmd_t e, c;
        bit   e2;
        @(negedge HCLK);
        cyc++;
        e2 = 0;
        if (rsp_valid) begin
            n_rsp++;
            if (rsp_err) n_rsp_err++;
            if (exp_q.size() == 0) check("rsp_spurious", 1, 0);
            else begin
                e = exp_q.pop_front();
                check("rsp_write", rsp_write, e.w);
                check("rsp_err", rsp_err, e.e);
                if (!e.w && !e.e) check("rsp_rdata", rsp_rdata, e.rd);
                if (e.lat >= 0) check("latency", 64'(cyc - e.cyc), 64'(e.lat));
            end
        end
        if (!s_dp) begin
            HREADY = 1'b1; HRESP = 1'b0;
        end else begin
            if (s_w) check("hwdata", HWDATA, s_d);
            if (s_wait > 0) begin
                HREADY = 1'b0; HRESP = 1'b0; s_wait--;
            end else if (s_e && !s_e1) begin
                HREADY = 1'b0; HRESP = 1'b1; s_e1 = 1;
            end else begin
                HREADY = 1'b1; HRESP = s_e;
                if (s_e) begin
                    e2 = 1;
                    check("err2_htrans", HTRANS, 2'b00);
                    check("err2_hsel", HSEL, 0);
                    HRDATA = {$urandom, $urandom};
                end else if (s_w) slv_mem[s_a[7:3]] = HWDATA;
                else HRDATA = slv_mem[s_a[7:3]];
                s_dp = 0;
            end
        end
        if (!HREADY && iss_q.size() != 0) begin
            check("hold_htrans", HTRANS, 2'b10);
            check("hold_haddr", HADDR, iss_q[0].a);
        end
        if (HREADY && !e2) begin
            check("htrans", HTRANS, iss_q.size() != 0 ? 2'b10 : 2'b00);
            check("hsel", HSEL, iss_q.size() != 0);
            if (iss_q.size() != 0) begin
                c = iss_q.pop_front();
                check("haddr", HADDR, c.a);
                check("hwrite", HWRITE, c.w);
                check("hsize", HSIZE, c.sz);
                check("hprot", HPROT, c.p);
                check("hmastlock", HMASTLOCK, c.l);
                check("hburst", HBURST, 3'b000);
                s_dp = 1; s_w = c.w; s_a = c.a; s_d = c.d; s_e = c.e; s_e1 = 0;
                s_wait = c.wt >= 0 ? c.wt : (zw ? 0 : $urandom_range(0, 2));
            end else begin
                check("hprot_idle", HPROT, 4'b0011);
                check("hmastlock_idle", HMASTLOCK, 0);
            end
        end
        if (!have && pend_q.size() != 0) begin
            cur = pend_q.pop_front(); have = 1;
        end else if (!have && $urandom_range(0, 99) < load) begin
            cur = rnd_cmd(); have = 1;
        end
        cmd_valid = have;
        cmd_write = cur.w; cmd_addr = cur.a; cmd_size = cur.sz;
        cmd_wdata = cur.d; cmd_prot = cur.p; cmd_lock = cur.l;
        #1;
        check("cmd_ready", cmd_ready, HREADY && !e2 && !rp);
        if (have && cmd_ready) begin
            accept_cmd(cur); have = 0;
        end
        rp = e2 && iss_q.size() != 0;
    endtask

    task automatic drain();
        int n;
        n = 0;
        while ((have || pend_q.size() != 0 || exp_q.size() != 0 || iss_q.size() != 0 || s_dp) && n < 300) begin
            tick(); n++;
        end
        if (n >= 300) check("drain_timeout", 1, 0);
        tick();
    endtask

    task automatic do_reset(input int cycles);
        @(negedge HCLK);
        HRESETn = 1'b0;
        for (int i = 0; i < cycles; i++) begin
            HREADY = 1'($urandom_range(0, 1)); HRESP = 1'($urandom_range(0, 1));
            cmd_valid = 1'($urandom_range(0, 1)); cmd_addr = {$urandom, $urandom};
            HRDATA = {$urandom, $urandom};
            #1;
            check("rst_htrans", HTRANS, 2'b00);
            check("rst_hsel", HSEL, 0);
            check("rst_hprot", HPROT, 4'b0011);
            check("rst_haddr", HADDR, 0);
            check("rst_hwdata", HWDATA, 0);
            check("rst_rsp_valid", rsp_valid, 0);
            check("rst_rsp_rdata", rsp_rdata, 0);
            check("rst_cmd_ready", cmd_ready, HREADY);
            @(negedge HCLK);
        end
        iss_q.delete(); exp_q.delete(); pend_q.delete();
        have = 0; rp = 0; s_dp = 0; n_rsp = 0; n_rsp_err = 0;
        for (int i = 0; i < 32; i++) ref_mem[i] = slv_mem[i];
        HREADY = 1'b1; HRESP = 1'b0; cmd_valid = 1'b0;
        HRESETn = 1'b1;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        cur = mk(0, 0, 0, -1, -1);
        for (int i = 0; i < 32; i++) begin ref_mem[i] = '0; slv_mem[i] = '0; end
        do_reset(4);
        pend_q.push_back(mk(1, 64'h10, 64'hDEADBEEF_CAFEF00D, -1, 3));
        drain();
        pend_q.push_back(mk(0, 64'h10, 64'h0, -1, 3));
        drain();
        for (int i = 0; i < 4; i++) pend_q.push_back(mk(1, 64'(i * 8), {$urandom, $urandom}, -1, 3));
        drain();
        pend_q.push_back(mk(1, 64'h20, 64'h1234_5678_9ABC_DEF0, 3, 6));
        pend_q.push_back(mk(0, 64'h20, 64'h0, -1, -1));
        drain();
        err_en = 1;
        pend_q.push_back(mk(1, 64'hC0, 64'h5555_AAAA_5555_AAAA, 0, 4));
        pend_q.push_back(mk(0, 64'h10, 64'h0, 0, 5));
        drain();
`ifdef MPSOC_AHB3_MASTER_STATS_EN
        check("stat_xfer", stat_xfer_cnt, 32'(n_rsp));
        check("stat_err", stat_err_cnt, 32'(n_rsp_err));
        @(negedge HCLK); stat_clr = 1'b1;
        @(negedge HCLK); stat_clr = 1'b0;
        check("stat_clr_xfer", stat_xfer_cnt, 0);
        check("stat_clr_err", stat_err_cnt, 0);
        n_rsp = 0; n_rsp_err = 0;
        for (int i = 0; i < 5; i++) pend_q.push_back(mk(1'(i & 1), i == 2 ? 64'hE8 : 64'(i * 8), {$urandom, $urandom}, -1, -1));
        drain();
        check("stat5_xfer", stat_xfer_cnt, 5);
        check("stat5_err", stat_err_cnt, 1);
`endif
        zw = 0; load = 70;
        for (int i = 0; i < 1500; i++) tick();
        do_reset(2);
        for (int i = 0; i < 1500; i++) tick();
        load = 0;
        drain();
`ifdef MPSOC_AHB3_MASTER_STATS_EN
        check("stat_rnd_xfer", stat_xfer_cnt, 32'(n_rsp));
        check("stat_rnd_err", stat_err_cnt, 32'(n_rsp_err));
`endif
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end
endmodule
